// File: rtl/leitor_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display reader.
package pacote_display;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CONTANDO = 2'd1,
    ACEITO   = 2'd2
  } estado_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int unsigned US = 0;
  localparam int unsigned DS = 1;
  localparam int unsigned UM = 2;
  localparam int unsigned DM = 3;

  function automatic logic ehUmQuente(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] indiceDigito(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'(DS);
      4'b0100: idx = 2'(UM);
      4'b1000: idx = 2'(DM);
      default: idx = 2'(US);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/leitor_display_decodificador.sv
// Combinational 7-segment (active-high) to BCD decoder; unknown patterns give 4'hF.
module decodificador_7seg_bcd
  import pacote_display::*;
(
  input  logic [6:0] segmentos,
  output logic [3:0] bcd,
  output logic       invalido
);

  // Table lookup of the ten legal digit shapes.
  always_comb begin
    bcd      = 4'hF;
    invalido = 1'b1;
    case (segmentos)
      SEG_0:   begin bcd = 4'd0; invalido = 1'b0; end
      SEG_1:   begin bcd = 4'd1; invalido = 1'b0; end
      SEG_2:   begin bcd = 4'd2; invalido = 1'b0; end
      SEG_3:   begin bcd = 4'd3; invalido = 1'b0; end
      SEG_4:   begin bcd = 4'd4; invalido = 1'b0; end
      SEG_5:   begin bcd = 4'd5; invalido = 1'b0; end
      SEG_6:   begin bcd = 4'd6; invalido = 1'b0; end
      SEG_7:   begin bcd = 4'd7; invalido = 1'b0; end
      SEG_8:   begin bcd = 4'd8; invalido = 1'b0; end
      SEG_9:   begin bcd = 4'd9; invalido = 1'b0; end
      default: begin bcd = 4'hF; invalido = 1'b1; end
    endcase
  end

endmodule

// File: rtl/leitor_display.sv
// Snoops a 4-digit multiplexed 7-segment bus, debounces each digit slot and
// publishes the last complete frame as BCD.
module leitor_display
  import pacote_display::*;
#(
  parameter int ESTAVEL         = 4,
  parameter int TIMEOUT         = 1_000_000,
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [3:0] digitos,
  input  logic [7:0] segmentos,
  output logic [3:0] us,
  output logic [3:0] ds,
  output logic [3:0] um,
  output logic [3:0] dm,
  output logic       quadroValido,
  output logic [3:0] erroSegmento,
  output logic       erroBarramento,
  output logic       semSinal
);

  localparam int CW = $clog2(ESTAVEL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ESTAVEL);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [3:0]       digMeta_r, digSync_r, snapDig_r;
  logic [6:0]       segMeta_r, segSync_r, snapSeg_r;
  logic [CW-1:0]    cnt_r, cntNext_s;
  logic [TW-1:0]    tmo_r, tmoNext_s;
  estado_t          estado_r, estadoNext_s;
  logic [3:0]       mascara_r, mascaraBase_s, mascaraNext_s;
  logic [3:0][3:0]  sombra_r;
  logic [3:0]       erroSeg_r;
  logic             quadroValido_r, erroBarramento_r, semSinal_r;
  logic [6:0]       segAtivo_s;
  logic [3:0]       bcd_s;
  logic [1:0]       idx_s;
  logic             invalido_s, mudou_s, umQuente_s, multiplo_s;
  logic             estabilizou_s, aceita_s, quadroCompleto_s;
  logic             unusedDp;

  assign unusedDp = segmentos[7];

  // Two-flop synchronizer for the asynchronous display bus.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      digMeta_r <= 4'd0;
      digSync_r <= 4'd0;
      segMeta_r <= 7'd0;
      segSync_r <= 7'd0;
    end else begin
      digMeta_r <= digitos;
      digSync_r <= digMeta_r;
      segMeta_r <= segmentos[6:0];
      segSync_r <= segMeta_r;
    end
  end

  assign segAtivo_s = SEG_ATIVO_BAIXO ? ~segSync_r : segSync_r;

  decodificador_7seg_bcd uDecod (
    .segmentos (segAtivo_s),
    .bcd       (bcd_s),
    .invalido  (invalido_s)
  );

  assign mudou_s    = (digSync_r != snapDig_r) || (segSync_r != snapSeg_r);
  assign umQuente_s = ehUmQuente(digSync_r);
  assign multiplo_s = (digSync_r != 4'd0) && !umQuente_s;
  assign idx_s      = indiceDigito(digSync_r);

  // Saturating stability count of the current {digitos, segments} pattern.
  always_comb begin
    cntNext_s = cnt_r;
    if (mudou_s) begin
      cntNext_s = CW'(1);
    end else if (cnt_r == CNT_MAX) begin
      cntNext_s = cnt_r;
    end else begin
      cntNext_s = cnt_r + CW'(1);
    end
  end

  // True only on the edge where a pattern first completes ESTAVEL clocks.
  assign estabilizou_s    = (cntNext_s == CNT_MAX) && (cnt_r != CNT_MAX);
  assign aceita_s         = (estado_r == CONTANDO) && umQuente_s && !mudou_s && estabilizou_s;
  assign quadroCompleto_s = (mascara_r == 4'b1111);
  assign mascaraBase_s    = quadroCompleto_s ? 4'd0 : mascara_r;
  assign mascaraNext_s    = aceita_s ? (mascaraBase_s | (4'd1 << idx_s)) : mascaraBase_s;
  assign tmoNext_s        = aceita_s ? {TW{1'b0}}
                          : ((tmo_r == TMO_MAX) ? tmo_r : tmo_r + TW'(1));

  // Next-state logic: blanking or a multi-digit select always drops to ESPERA.
  always_comb begin
    estadoNext_s = estado_r;
    if (!umQuente_s) begin
      estadoNext_s = ESPERA;
    end else begin
      case (estado_r)
        ESPERA:   estadoNext_s = CONTANDO;
        CONTANDO: estadoNext_s = aceita_s ? ACEITO : CONTANDO;
        ACEITO:   estadoNext_s = mudou_s ? CONTANDO : ACEITO;
        default:  estadoNext_s = ESPERA;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      estado_r <= ESPERA;
    end else begin
      estado_r <= estadoNext_s;
    end
  end

  // Snapshot, counters, shadow capture and frame publication.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      snapDig_r        <= 4'd0;
      snapSeg_r        <= 7'd0;
      cnt_r            <= {CW{1'b0}};
      tmo_r            <= {TW{1'b0}};
      mascara_r        <= 4'd0;
      sombra_r         <= 16'd0;
      erroSeg_r        <= 4'd0;
      us               <= 4'd0;
      ds               <= 4'd0;
      um               <= 4'd0;
      dm               <= 4'd0;
      quadroValido_r   <= 1'b0;
      erroBarramento_r <= 1'b0;
      semSinal_r       <= 1'b0;
    end else begin
      snapDig_r        <= digSync_r;
      snapSeg_r        <= segSync_r;
      cnt_r            <= cntNext_s;
      tmo_r            <= tmoNext_s;
      mascara_r        <= mascaraNext_s;
      quadroValido_r   <= quadroCompleto_s;
      erroBarramento_r <= multiplo_s && estabilizou_s;
      semSinal_r       <= (tmoNext_s == TMO_MAX);
      if (aceita_s) begin
        sombra_r[idx_s]  <= bcd_s;
        erroSeg_r[idx_s] <= invalido_s;
      end
      // Publication reads the pre-edge shadows, so a same-edge accept lands in the next frame.
      if (quadroCompleto_s) begin
        us <= sombra_r[US];
        ds <= sombra_r[DS];
        um <= sombra_r[UM];
        dm <= sombra_r[DM];
      end
    end
  end

  assign quadroValido   = quadroValido_r;
  assign erroSegmento   = erroSeg_r;
  assign erroBarramento = erroBarramento_r;
  assign semSinal       = semSinal_r;

endmodule

// File: tb/tb_leitor_display.sv
// Self-checking bench for leitor_display: directed scenarios plus random scans,
// checked every cycle against a run-length reference model.
module tb_leitor_display;

  localparam int ESTAVEL = 4;
  localparam int TIMEOUT = 20;

  logic       clock = 1'b0;
  logic       resetN;
  logic [3:0] digitos;
  logic [7:0] segmentos;
  logic [3:0] us, ds, um, dm, erroSegmento;
  logic       quadroValido, erroBarramento, semSinal;

  int testsRun    = 0;
  int testsFailed = 0;
  int qvCount     = 0;
  int busCount    = 0;

  logic [6:0] codigos [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state
  logic [3:0] mS1Dig, mS2Dig, mPrevDig;
  logic [6:0] mS1Seg, mS2Seg, mPrevSeg;
  int         mRun, mTmo;
  logic [3:0] mMask, mErr;
  logic [3:0] mShadow [4];
  logic [3:0] mOut [4];
  logic       mQv, mBus, mSem;

  always #5 clock = ~clock;

  leitor_display #(.ESTAVEL(ESTAVEL), .TIMEOUT(TIMEOUT), .SEG_ATIVO_BAIXO(1'b1)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .digitos        (digitos),
    .segmentos      (segmentos),
    .us             (us),
    .ds             (ds),
    .um             (um),
    .dm             (dm),
    .quadroValido   (quadroValido),
    .erroSegmento   (erroSegmento),
    .erroBarramento (erroBarramento),
    .semSinal       (semSinal)
  );

  function automatic logic [4:0] decodeRef(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (codigos[i] == s) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'hF};
  endfunction

  task automatic modelReset();
    mS1Dig = 4'd0; mS2Dig = 4'd0; mPrevDig = 4'd0;
    mS1Seg = 7'd0; mS2Seg = 7'd0; mPrevSeg = 7'd0;
    mRun = 0; mTmo = 0; mMask = 4'd0; mErr = 4'd0;
    mQv = 1'b0; mBus = 1'b0; mSem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mShadow[i] = 4'd0;
      mOut[i]    = 4'd0;
    end
  endtask

  // One clock of the spec: 2-cycle input delay, run length, accept at exactly ESTAVEL.
  task automatic modelEdge();
    logic [3:0] pDig;
    logic [6:0] pSeg;
    logic [4:0] dec;
    int         idx;
    pDig = mS2Dig; pSeg = mS2Seg;
    mS2Dig = mS1Dig; mS2Seg = mS1Seg;
    mS1Dig = digitos; mS1Seg = segmentos[6:0];
    if (pDig == mPrevDig && pSeg == mPrevSeg) mRun++;
    else mRun = 1;
    mPrevDig = pDig; mPrevSeg = pSeg;
    mQv = 1'b0;
    if (mMask == 4'hF) begin
      for (int i = 0; i < 4; i++) mOut[i] = mShadow[i];
      mQv = 1'b1;
      mMask = 4'd0;
    end
    if ($countones(pDig) == 1 && mRun == ESTAVEL) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (pDig[i]) idx = i;
      dec = decodeRef(~pSeg);
      mShadow[idx] = dec[3:0];
      mMask[idx]   = 1'b1;
      mErr[idx]    = dec[4];
      mTmo = 0;
    end else if (mTmo < TIMEOUT) begin
      mTmo++;
    end
    mSem = (mTmo == TIMEOUT);
    mBus = ($countones(pDig) >= 2) && (mRun == ESTAVEL);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("quadroValido", 32'(quadroValido), 32'(mQv));
    chk("erroBarramento", 32'(erroBarramento), 32'(mBus));
    chk("semSinal", 32'(semSinal), 32'(mSem));
    chk("frame", {16'd0, dm, um, ds, us}, {16'd0, mOut[3], mOut[2], mOut[1], mOut[0]});
    chk("erroSegmento", 32'(erroSegmento), 32'(mErr));
  endtask

  task automatic tick(input logic [3:0] d, input logic [7:0] s);
    digitos   = d;
    segmentos = s;
    @(posedge clock);
    #1;
    modelEdge();
    checkAll();
    qvCount  += int'(quadroValido);
    busCount += int'(erroBarramento);
  endtask

  task automatic slot(input logic [3:0] d, input logic [6:0] code, input int n);
    for (int i = 0; i < n; i++) tick(d, ~{1'($urandom_range(0, 1)), code});
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(4'd0, 8'hFF);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    #1;
    modelReset();
    checkAll();
    chk("reset_zero", {7'd0, dm, um, ds, us, erroSegmento, quadroValido, erroBarramento, semSinal}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    logic [3:0] d;
    logic [6:0] s;
    int         r;
    resetN    = 1'b0;
    digitos   = 4'd0;
    segmentos = 8'hFF;
    doReset();

    // Full scan 4-2-1-0
    qvCount = 0;
    blank(3);
    slot(4'b0001, 7'h66, 8);
    slot(4'b0010, 7'h5B, 8);
    slot(4'b0100, 7'h06, 8);
    slot(4'b1000, 7'h3F, 8);
    blank(4);
    chk("scan_qv_count", 32'(qvCount), 32'd1);
    chk("scan_frame", {16'd0, dm, um, ds, us}, 32'h0000_0124);
    chk("scan_erroSeg", 32'(erroSegmento), 32'd0);

    // Short Ds slot is not accepted, so no frame
    qvCount = 0;
    slot(4'b0001, 7'h06, 8);
    slot(4'b0010, 7'h7F, 3);
    slot(4'b0100, 7'h07, 8);
    slot(4'b1000, 7'h7D, 8);
    blank(4);
    chk("short_slot_no_qv", 32'(qvCount), 32'd0);

    // Invalid Ds pattern completes the frame with F and an error flag
    slot(4'b0010, 7'h49, 8);
    blank(4);
    chk("invalid_qv_count", 32'(qvCount), 32'd1);
    chk("invalid_frame", {16'd0, dm, um, ds, us}, 32'h0000_67F1);
    chk("invalid_erroSeg", 32'(erroSegmento), 32'd2);

    // Two digits selected together
    busCount = 0;
    blank(2);
    slot(4'b0011, 7'h06, 6);
    blank(4);
    chk("bus_err_count", 32'(busCount), 32'd1);

    // Idle bus timeout, then recovery on one accept
    blank(25);
    chk("timeout_high", 32'(semSinal), 32'd1);
    slot(4'b0001, 7'h6D, 5);
    blank(6);
    chk("timeout_cleared", 32'(semSinal), 32'd0);

    // Reset mid-frame discards partial captures
    qvCount = 0;
    slot(4'b0001, 7'h7F, 8);
    slot(4'b0010, 7'h6F, 8);
    slot(4'b0100, 7'h4F, 8);
    doReset();
    slot(4'b1000, 7'h5B, 8);
    slot(4'b0001, 7'h3F, 8);
    slot(4'b0010, 7'h06, 8);
    blank(4);
    chk("post_reset_3_accepts", 32'(qvCount), 32'd0);
    slot(4'b0100, 7'h4F, 8);
    blank(4);
    chk("post_reset_qv_count", 32'(qvCount), 32'd1);
    chk("post_reset_frame", {16'd0, dm, um, ds, us}, 32'h0000_2310);

    // Random scans against the model
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        d = 4'd1 << $urandom_range(0, 3);
      end else if (r < 8) begin
        d = 4'd0;
      end else begin
        do d = 4'($urandom_range(0, 15)); while ($countones(d) < 2);
      end
      if ($urandom_range(0, 4) != 0) s = codigos[$urandom_range(0, 9)];
      else s = 7'($urandom_range(0, 127));
      slot(d, s, int'($urandom_range(1, 8)));
    end
    blank(6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
